inst_prefetch_buffer: RTL

//  Instruction fetch front-end between the instruction memory and the pipeline IF stage.
//  - Issues sequential fetch requests to imem over a req/gnt/rvalid handshake.
//  - Buffers returned {pc, inst} pairs in a small queue.
//  - Presents the queue head to IF with a valid/ready handshake.
//  - On a control-flow redirect from the datapath (jal/branch/jalr/mret/trap), flushes the queue
//    and drops responses that are still in flight.

---
 rtl/inst_prefetch_buffer_pkg.sv | 19 +
 rtl/inst_prefetch_buffer_fifo.sv | 65 ++++++
 rtl/inst_prefetch_buffer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared RISC-V fetch constants and the {pc, inst} entry layout used by the
// prefetch buffer and its queue.
package inst_prefetch_buffer_pkg;

   localparam int          INST_W           = 32;
   localparam int          ENTRY_W          = 2 * INST_W;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0001_0000;

   typedef struct packed {
      logic [INST_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
      return {addr[INST_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_prefetch_buffer_fifo.sv
// prefetch_fifo: synchronous DEPTH-entry queue of {pc, inst} pairs with
// synchronous clear; pointers carry one extra bit to tell full from empty.
module prefetch_fifo
   import inst_prefetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset_x,
   input  logic                    i_clear,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic [ENTRY_W-1:0]      i_data,
   output logic [ENTRY_W-1:0]      o_data,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_empty,
   output logic                    o_full
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic               do_push;
   logic               do_pop;

   assign o_count = wr_ptr_q - rd_ptr_q;
   assign o_empty = (wr_ptr_q == rd_ptr_q);
   assign o_full  = (o_count == DEPTH_CNT);
   assign o_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = i_push & ~i_clear;
   assign do_pop  = i_pop & ~o_empty & ~i_clear;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_x) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// inst_prefetch_buffer: sequential imem fetcher with a {pc, inst} queue and redirect flush.
// Optional macro PREFETCH_BYPASS_EN presents a response arriving at an empty queue in the same cycle.
module inst_prefetch_buffer
   import inst_prefetch_buffer_pkg::*;
#(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_x,
   output logic        o_imemReq,
   output logic [31:0] o_imemAddr,
   input  logic        i_imemGnt,
   input  logic        i_imemRvalid,
   input  logic [31:0] i_imemRdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirectPC,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc
);

   localparam int            AW        = $clog2(DEPTH);
   localparam int            CW        = AW + 2;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;

   logic [AW:0]   fifo_count;
   logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
   fetch_entry_t  fifo_wdata, fifo_rdata;
   logic [CW-1:0] slots_in_use;
   logic          gnt_fire, rsp_fire, rsp_drop, rsp_keep, bypass_hit;

   // Queue slots are reserved at request time; responses that will be dropped hold no slot.
   assign slots_in_use = CW'(fifo_count) + outstanding_q - drop_cnt_q;
   assign o_imemReq    = reset_x & ~i_redirect & (slots_in_use < DEPTH_C) & (outstanding_q < MAX_OUT_C);
   assign o_imemAddr   = fetch_pc_q;

   assign gnt_fire = o_imemReq & i_imemGnt;
   assign rsp_fire = i_imemRvalid & (outstanding_q != '0);
   assign rsp_drop = rsp_fire & (drop_cnt_q != '0);
   assign rsp_keep = rsp_fire & ~rsp_drop & ~i_redirect;

`ifdef PREFETCH_BYPASS_EN
   assign bypass_hit = rsp_keep & fifo_empty;
`else
   assign bypass_hit = 1'b0;
`endif

   assign fifo_wdata = '{pc: resp_pc_q, inst: i_imemRdata};
   assign fifo_push  = rsp_keep & ~(bypass_hit & i_ready);
   assign fifo_pop   = ~fifo_empty & i_ready & ~i_redirect;

   prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_x (reset_x),
      .i_clear (i_redirect),
      .i_push  (fifo_push),
      .i_pop   (fifo_pop),
      .i_data  (fifo_wdata),
      .o_data  (fifo_rdata),
      .o_count (fifo_count),
      .o_empty (fifo_empty),
      .o_full  (fifo_full)
   );

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
      drop_cnt_d    = drop_cnt_q;
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
      if (rsp_keep) resp_pc_d  = resp_pc_q + 32'd4;
      // Everything still in flight after this cycle belongs to the old stream.
      if (i_redirect) begin
         fetch_pc_d = word_align(i_redirectPC);
         resp_pc_d  = word_align(i_redirectPC);
         drop_cnt_d = outstanding_q - CW'(rsp_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_x) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   always_comb begin
      o_valid = 1'b0;
      o_inst  = NOP_INST;
      o_pc    = resp_pc_q;
      if (!fifo_empty) begin
         o_valid = 1'b1;
         o_inst  = fifo_rdata.inst;
         o_pc    = fifo_rdata.pc;
      end else if (bypass_hit) begin
         o_valid = 1'b1;
         o_inst  = i_imemRdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_x) begin
         assert (!(i_imemRvalid && outstanding_q == '0));
         assert (!(fifo_push && fifo_full && !fifo_pop));
      end
   end

endmodule
